// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared direction encodings and {y,x} address helpers for the NoC.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int DIR_W = 5;

  localparam logic [DIR_W-1:0] DIR_EAST  = 5'b00001;
  localparam logic [DIR_W-1:0] DIR_WEST  = 5'b00010;
  localparam logic [DIR_W-1:0] DIR_NORTH = 5'b00100;
  localparam logic [DIR_W-1:0] DIR_SOUTH = 5'b01000;
  localparam logic [DIR_W-1:0] DIR_LOCAL = 5'b10000;

  // Addresses are packed {y, x}; x occupies the low cw bits, y the next cw bits.
  function automatic int unsigned addr_x(input logic [31:0] addr, input int unsigned cw);
    return addr & ((32'd1 << cw) - 32'd1);
  endfunction

  function automatic int unsigned addr_y(input logic [31:0] addr, input int unsigned cw);
    return (addr >> cw) & ((32'd1 << cw) - 32'd1);
  endfunction

  // XY routing: resolve x first, then y; all comparisons unsigned.
  function automatic logic [DIR_W-1:0] xy_dir(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned my_x,
                                              input int unsigned my_y);
    if (x > my_x)      return DIR_EAST;
    else if (x < my_x) return DIR_WEST;
    else if (y > my_y) return DIR_NORTH;
    else if (y < my_y) return DIR_SOUTH;
    else               return DIR_LOCAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_injector_q_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_injector_q_if
// Purpose  : Slot, local-injection and output bundle of the injection stage.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_injector_q_if #(
  parameter int NUM_PORTS = 4,
  parameter int COORD_W   = 3,
  parameter int DATA_W    = 16
);

  logic [NUM_PORTS-1:0]           in_valid;
  logic [NUM_PORTS*2*COORD_W-1:0] in_dst;
  logic [NUM_PORTS*DATA_W-1:0]    in_data;

  logic                           inj_valid;
  logic                           inj_ready;
  logic [2*COORD_W-1:0]           inj_dst;
  logic [DATA_W-1:0]              inj_data;

  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS*2*COORD_W-1:0] out_dst;
  logic [NUM_PORTS*DATA_W-1:0]    out_data;
  logic [NUM_PORTS-1:0]           out_inj;
  logic [noc_pkg::DIR_W-1:0]      inj_dir;
  logic                           starved;

  modport slave (
    input  in_valid, in_dst, in_data, inj_valid, inj_dst, inj_data,
    output inj_ready, out_valid, out_dst, out_data, out_inj, inj_dir, starved
  );

  modport master (
    output in_valid, in_dst, in_data, inj_valid, inj_dst, inj_data,
    input  inj_ready, out_valid, out_dst, out_data, out_inj, inj_dir, starved
  );

endinterface
`default_nettype wire

// File: rtl/inj_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inj_fifo
// Purpose  : Small synchronous FIFO holding queued local flits.
// Revision : 1.0 - initial release
// ============================================================================
module inj_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_injector_q.sv
`default_nettype none
// ============================================================================
// Module   : noc_injector_q
// Purpose  : Queues local flits and injects the head into a free router slot
//            (round-robin), computing its XY direction and flagging starvation.
// Revision : 1.0 - initial release
// ============================================================================
module noc_injector_q
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int COORD_W      = 3,
  parameter int DATA_W       = 16,
  parameter int MY_X         = 4,
  parameter int MY_Y         = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  noc_injector_q_if.slave bus
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam int ENT_W  = DATA_W + ADDR_W;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [STV_W-1:0] c_starve_max = STV_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] c_last_slot  = PTR_W'(NUM_PORTS - 1);

  logic [ENT_W-1:0]            w_head;
  logic                        w_full;
  logic                        w_empty;
  logic [CNT_W-1:0]            w_count;
  logic [ADDR_W-1:0]           w_head_dst;
  logic [DATA_W-1:0]           w_head_data;

  logic                        w_found;
  logic                        w_inject;
  logic [PTR_W-1:0]            w_sel;
  logic [PTR_W-1:0]            w_cand;
  logic [PTR_W-1:0]            w_rr_nxt;
  int                          w_idx;
  logic [NUM_PORTS-1:0]        w_take;
  logic [DIR_W-1:0]            w_dir;
  logic [STV_W-1:0]            w_starve_nxt;

  logic [NUM_PORTS-1:0]        w_nxt_valid;
  logic [NUM_PORTS*ADDR_W-1:0] w_nxt_dst;
  logic [NUM_PORTS*DATA_W-1:0] w_nxt_data;

  logic [PTR_W-1:0]            r_rr_ptr;
  logic [STV_W-1:0]            r_starve_cnt;
  logic                        r_starved;
  logic [NUM_PORTS-1:0]        r_out_valid;
  logic [NUM_PORTS*ADDR_W-1:0] r_out_dst;
  logic [NUM_PORTS*DATA_W-1:0] r_out_data;
  logic [NUM_PORTS-1:0]        r_out_inj;
  logic [DIR_W-1:0]            r_inj_dir;

  inj_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.inj_valid),
    .pop   (w_inject),
    .wdata ({bus.inj_dst, bus.inj_data}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_head_dst  = w_head[ENT_W-1 -: ADDR_W];
  assign w_head_data = w_head[DATA_W-1:0];

  // First free slot scanning from the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx  = (int'(r_rr_ptr) + k) % NUM_PORTS;
      w_cand = PTR_W'(w_idx);
      if (!w_found && !bus.in_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_inject = w_found && !w_empty;
  assign w_take   = w_inject ? (NUM_PORTS'(1) << w_sel) : '0;
  assign w_rr_nxt = (w_sel == c_last_slot) ? '0 : w_sel + 1'b1;
  assign w_dir    = xy_dir(addr_x(32'(w_head_dst), COORD_W),
                           addr_y(32'(w_head_dst), COORD_W),
                           MY_X, MY_Y);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    assign w_nxt_valid[i] = bus.in_valid[i] | w_take[i];
    assign w_nxt_dst[i*ADDR_W +: ADDR_W] =
      w_take[i] ? w_head_dst : bus.in_dst[i*ADDR_W +: ADDR_W];
    assign w_nxt_data[i*DATA_W +: DATA_W] =
      w_take[i] ? w_head_data : bus.in_data[i*DATA_W +: DATA_W];
  end

  // A pending flit that is not injected means every slot was occupied.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if ((w_count == '0) || w_inject)
      w_starve_nxt = '0;
    else if (r_starve_cnt != c_starve_max)
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
      r_starved    <= 1'b0;
      r_out_valid  <= '0;
      r_out_dst    <= '0;
      r_out_data   <= '0;
      r_out_inj    <= '0;
      r_inj_dir    <= '0;
    end else begin
      r_out_valid  <= w_nxt_valid;
      r_out_dst    <= w_nxt_dst;
      r_out_data   <= w_nxt_data;
      r_out_inj    <= w_take;
      r_inj_dir    <= w_inject ? w_dir : '0;
      r_starve_cnt <= w_starve_nxt;
      r_starved    <= (w_starve_nxt == c_starve_max);
      if (w_inject) r_rr_ptr <= w_rr_nxt;
    end
  end

  assign bus.inj_ready = !w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_dst   = r_out_dst;
  assign bus.out_data  = r_out_data;
  assign bus.out_inj   = r_out_inj;
  assign bus.inj_dir   = r_inj_dir;
  assign bus.starved   = r_starved;

endmodule
`default_nettype wire

// File: tb/tb_noc_injector_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_injector_q
// Purpose  : Self-checking bench for noc_injector_q with an injection scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_injector_q;

  localparam int NP = 4;
  localparam int CW = 3;
  localparam int DW = 16;
  localparam int AW = 2 * CW;
  localparam int MX = 4;
  localparam int MY = 4;
  localparam int FD = 4;
  localparam int SL = 15;

  typedef struct packed {
    logic [NP-1:0] slot;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic [4:0]    dir;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  noc_injector_q_if #(.NUM_PORTS(NP), .COORD_W(CW), .DATA_W(DW)) bus();

  noc_injector_q #(
    .NUM_PORTS(NP), .COORD_W(CW), .DATA_W(DW), .MY_X(MX), .MY_Y(MY),
    .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [4:0] ref_dir(input logic [AW-1:0] d);
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    x = d[CW-1:0];
    y = d[AW-1:CW];
    if (x > 3'd4)      return 5'b00001;
    else if (x < 3'd4) return 5'b00010;
    else if (y > 3'd4) return 5'b00100;
    else if (y < 3'd4) return 5'b01000;
    else               return 5'b10000;
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] oh);
    for (int i = 0; i < NP; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NP-1:0] slot, input logic [AW-1:0] dst,
                          input logic [DW-1:0] data);
    exp_t e;
    e.slot = slot;
    e.dst  = dst;
    e.data = data;
    e.dir  = ref_dir(dst);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_dst    = '0;
    bus.in_data   = '0;
    bus.inj_valid = 1'b0;
    bus.inj_dst   = '0;
    bus.inj_data  = '0;
    step();
    step();
    checks++;
    if ({bus.out_valid, bus.out_inj, bus.inj_dir, bus.starved} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got valid=%b inj=%b dir=%b starved=%b, expected all 0",
               bus.out_valid, bus.out_inj, bus.inj_dir, bus.starved);
    end
    checks++;
    if ({bus.out_dst, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got dst=%h data=%h, expected 0", bus.out_dst, bus.out_data);
    end
    checks++;
    if (bus.inj_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 1", bus.inj_ready);
    end
    rst_n = 1'b1;
    step();
    // Queue three flits with all slots busy, then reset mid-stream.
    bus.in_valid = '1;
    bus.in_dst   = 24'h5A5A5A;
    bus.in_data  = 64'h1111_2222_3333_4444;
    for (int k = 0; k < 3; k++) begin
      bus.inj_valid = 1'b1;
      bus.inj_dst   = AW'(k + 9);
      bus.inj_data  = DW'(16'h0E00 + k);
      step();
    end
    bus.inj_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 4'b1111) begin
      errors++;
      $display("FAIL reset_pre_valid: got %b, expected 1111", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_inj, bus.inj_dir, bus.starved, bus.out_dst, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b dst=%h data=%h, expected 0",
               bus.out_valid, bus.out_dst, bus.out_data);
    end
    checks++;
    if (bus.inj_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_ready: got %b, expected 1", bus.inj_ready);
    end
    step();
    rst_n        = 1'b1;
    bus.in_valid = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({bus.out_inj, bus.inj_dir, bus.out_valid} !== '0) begin
        errors++;
        $display("FAIL reset_flush: cycle %0d got inj=%b dir=%b valid=%b, expected 0",
                 c, bus.out_inj, bus.inj_dir, bus.out_valid);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    bus.in_valid  = 4'b1011;
    bus.in_dst    = {6'h11, 6'h22, 6'h33, 6'h05};
    bus.in_data   = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    bus.inj_valid = 1'b1;
    bus.inj_dst   = {3'd4, 3'd6};
    bus.inj_data  = 16'h1234;
    push_exp(4'b0100, {3'd4, 3'd6}, 16'h1234);
    step();
    bus.inj_valid = 1'b0;
    checks++;
    if ({bus.out_inj, bus.out_valid, bus.out_dst} !== {4'b0000, 4'b1011, 6'h11, 6'h22, 6'h33, 6'h05}) begin
      errors++;
      $display("FAIL single_nobypass: got inj=%b valid=%b dst=%h, expected inj=0000 valid=1011 dst=%h",
               bus.out_inj, bus.out_valid, bus.out_dst, {6'h11, 6'h22, 6'h33, 6'h05});
    end
    bus.in_dst[5:0]   = 6'h2A;
    bus.in_data[15:0] = 16'hBEEF;
    step();
    checks++;
    if (bus.out_inj !== 4'b0100 || sb.size() == 0) begin
      errors++;
      $display("FAIL single_slot: got inj=%b, expected 0100", bus.out_inj);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bus.out_dst[2*AW +: AW], bus.out_data[2*DW +: DW], bus.inj_dir, bus.out_valid} !==
          {e.dst, e.data, e.dir, 4'b1111}) begin
        errors++;
        $display("FAIL single_flit: got dst=%h data=%h dir=%b valid=%b, expected dst=%h data=%h dir=%b valid=1111",
                 bus.out_dst[2*AW +: AW], bus.out_data[2*DW +: DW], bus.inj_dir, bus.out_valid,
                 e.dst, e.data, e.dir);
      end
    end
    checks++;
    if ({bus.out_dst[5:0], bus.out_data[15:0]} !== {6'h2A, 16'hBEEF}) begin
      errors++;
      $display("FAIL single_pass: got dst0=%h data0=%h, expected 2a beef",
               bus.out_dst[5:0], bus.out_data[15:0]);
    end
    bus.in_valid = '1;
    step();
    checks++;
    if ({bus.out_inj, bus.inj_dir} !== '0) begin
      errors++;
      $display("FAIL single_idle: got inj=%b dir=%b, expected 0", bus.out_inj, bus.inj_dir);
    end
  endtask

  task automatic test_round_robin();
    exp_t          e;
    int            s;
    logic [AW-1:0] dl [5];
    logic [NP-1:0] sl [5];
    dl[0] = {3'd4, 3'd4}; dl[1] = {3'd2, 3'd4}; dl[2] = {3'd4, 3'd1};
    dl[3] = {3'd4, 3'd6}; dl[4] = {3'd7, 3'd4};
    sl[0] = 4'b0001; sl[1] = 4'b0010; sl[2] = 4'b0100; sl[3] = 4'b1000; sl[4] = 4'b0001;
    rst_n = 1'b0;
    step();
    rst_n        = 1'b1;
    bus.in_valid = '0;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        bus.inj_valid = 1'b1;
        bus.inj_dst   = dl[c];
        bus.inj_data  = DW'(16'h0100 + c);
        push_exp(sl[c], dl[c], DW'(16'h0100 + c));
      end else begin
        bus.inj_valid = 1'b0;
      end
      step();
      if (bus.out_inj != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rr_extra: got inj=%b, expected no injection", bus.out_inj);
        end else begin
          e = sb.pop_front();
          s = oh_idx(bus.out_inj);
          if ({bus.out_inj, bus.out_dst[s*AW +: AW], bus.out_data[s*DW +: DW], bus.inj_dir} !==
              {e.slot, e.dst, e.data, e.dir}) begin
            errors++;
            $display("FAIL rr_inject: got inj=%b dst=%h data=%h dir=%b, expected inj=%b dst=%h data=%h dir=%b",
                     bus.out_inj, bus.out_dst[s*AW +: AW], bus.out_data[s*DW +: DW], bus.inj_dir,
                     e.slot, e.dst, e.data, e.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d flits outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_full_backpressure();
    exp_t          e;
    int            s;
    logic [NP-1:0] sl [4];
    sl[0] = 4'b0010; sl[1] = 4'b0100; sl[2] = 4'b1000; sl[3] = 4'b0001;
    bus.in_valid = '1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.inj_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready_pre: push %0d got ready=%b, expected 1", k, bus.inj_ready);
      end
      bus.inj_valid = 1'b1;
      bus.inj_dst   = {3'd4, 3'(k)};
      bus.inj_data  = DW'(16'h0200 + k);
      push_exp(sl[k], {3'd4, 3'(k)}, DW'(16'h0200 + k));
      step();
    end
    bus.inj_valid = 1'b0;
    checks++;
    if (bus.inj_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b, expected 0", bus.inj_ready);
    end
    bus.inj_valid = 1'b1;
    bus.inj_dst   = {3'd7, 3'd7};
    bus.inj_data  = 16'hDEAD;
    step();
    bus.inj_valid = 1'b0;
    checks++;
    if (bus.inj_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: got ready=%b, expected 0", bus.inj_ready);
    end
    bus.in_valid = 4'b1101;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        checks++;
        if ({bus.inj_ready, bus.out_inj} !== {1'b1, 4'b0010}) begin
          errors++;
          $display("FAIL full_release: got ready=%b inj=%b, expected ready=1 inj=0010",
                   bus.inj_ready, bus.out_inj);
        end
        bus.in_valid = '0;
      end
      if (bus.out_inj != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL full_extra: got inj=%b data=%h, expected no injection",
                   bus.out_inj, bus.out_data);
        end else begin
          e = sb.pop_front();
          s = oh_idx(bus.out_inj);
          if ({bus.out_inj, bus.out_dst[s*AW +: AW], bus.out_data[s*DW +: DW], bus.inj_dir} !==
              {e.slot, e.dst, e.data, e.dir}) begin
            errors++;
            $display("FAIL full_inject: got inj=%b dst=%h data=%h dir=%b, expected inj=%b dst=%h data=%h dir=%b",
                     bus.out_inj, bus.out_dst[s*AW +: AW], bus.out_data[s*DW +: DW], bus.inj_dir,
                     e.slot, e.dst, e.data, e.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got %0d flits outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    int   exp_cnt;
    bus.in_valid  = '1;
    bus.inj_valid = 1'b1;
    bus.inj_dst   = {3'd6, 3'd4};
    bus.inj_data  = 16'h5757;
    push_exp(4'b1000, {3'd6, 3'd4}, 16'h5757);
    step();
    bus.inj_valid = 1'b0;
    exp_cnt = 0;
    checks++;
    if (bus.starved !== 1'b0) begin
      errors++;
      $display("FAIL starve_init: got %b, expected 0", bus.starved);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (exp_cnt < SL) exp_cnt++;
      checks++;
      if (bus.starved !== (exp_cnt == SL)) begin
        errors++;
        $display("FAIL starve_count: cycle %0d got starved=%b, expected %b", c, bus.starved, exp_cnt == SL);
      end
    end
    bus.in_valid = 4'b0111;
    step();
    checks++;
    if (bus.out_inj !== 4'b1000 || sb.size() == 0) begin
      errors++;
      $display("FAIL starve_inject: got inj=%b, expected 1000", bus.out_inj);
    end else begin
      e = sb.pop_front();
      if ({bus.out_dst[3*AW +: AW], bus.out_data[3*DW +: DW], bus.inj_dir, bus.starved} !==
          {e.dst, e.data, e.dir, 1'b0}) begin
        errors++;
        $display("FAIL starve_flit: got dst=%h data=%h dir=%b starved=%b, expected dst=%h data=%h dir=%b starved=0",
                 bus.out_dst[3*AW +: AW], bus.out_data[3*DW +: DW], bus.inj_dir, bus.starved,
                 e.dst, e.data, e.dir);
      end
    end
    bus.in_valid = '1;
    step();
    checks++;
    if ({bus.starved, bus.out_inj} !== '0) begin
      errors++;
      $display("FAIL starve_clear: got starved=%b inj=%b, expected 0", bus.starved, bus.out_inj);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   n;
    bus.in_valid = '1;
    for (int k = 0; k < 2; k++) begin
      bus.inj_valid = 1'b1;
      bus.inj_dst   = {3'(k + 1), 3'd5};
      bus.inj_data  = DW'(16'h0300 + k);
      push_exp(4'b0001, {3'(k + 1), 3'd5}, DW'(16'h0300 + k));
      step();
    end
    bus.in_valid = 4'b1110;
    for (int c = 0; c < 8; c++) begin
      bus.inj_valid = 1'b1;
      bus.inj_dst   = {3'(c), 3'(7 - c)};
      bus.inj_data  = DW'(16'h0400 + c);
      bus.in_data   = {$urandom, $urandom};
      push_exp(4'b0001, {3'(c), 3'(7 - c)}, DW'(16'h0400 + c));
      step();
      checks++;
      if (bus.inj_ready !== 1'b1 || bus.out_inj !== 4'b0001 || sb.size() == 0) begin
        errors++;
        $display("FAIL simul_step: cycle %0d got ready=%b inj=%b, expected ready=1 inj=0001",
                 c, bus.inj_ready, bus.out_inj);
      end else begin
        e = sb.pop_front();
        if ({bus.out_dst[AW-1:0], bus.out_data[DW-1:0], bus.inj_dir} !== {e.dst, e.data, e.dir}) begin
          errors++;
          $display("FAIL simul_order: cycle %0d got dst=%h data=%h dir=%b, expected dst=%h data=%h dir=%b",
                   c, bus.out_dst[AW-1:0], bus.out_data[DW-1:0], bus.inj_dir, e.dst, e.data, e.dir);
        end
      end
    end
    bus.inj_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.out_inj != '0) begin
        n++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL simul_extra: got inj=%b, expected no injection", bus.out_inj);
        end else begin
          e = sb.pop_front();
          if ({bus.out_inj, bus.out_dst[AW-1:0], bus.out_data[DW-1:0]} !== {e.slot, e.dst, e.data}) begin
            errors++;
            $display("FAIL simul_tail: got inj=%b dst=%h data=%h, expected inj=%b dst=%h data=%h",
                     bus.out_inj, bus.out_dst[AW-1:0], bus.out_data[DW-1:0], e.slot, e.dst, e.data);
          end
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL simul_count: got %0d tail injections, expected 2", n);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simul_drain: got %0d flits outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_backpressure();
    test_starvation();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
